// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single pipelined main memory between the instruction cache and
// the data cache. One requester is granted at a time. A granted refill issues
// BLK_WORDS consecutive word reads, one per cycle, and steers each returned
// word into the granted cache's data array. A granted write-through store
// issues a single write cycle.
//
// Grant priority in IDLE (fixed): d_wr > d_miss > i_miss.
//
// After reset the arbiter sits in DRAIN for MEM_LAT cycles. Reads issued by
// a fill that the reset aborted can still come back during that window, and
// they are dropped there instead of being written into a cache.
//
// Optional feature:
//   MEM_ARB_PERF_CNT_EN  when defined, i_fill_cnt / d_fill_cnt count completed
//                        fills and busy_cyc counts busy cycles outside DRAIN.
//                        All three saturate at 0xFFFF and clear on rst. When
//                        undefined, the three ports are tied to zero.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   i_miss, i_addr      I-cache refill request (level) and miss address
//   d_miss, d_addr      D-cache refill request (level) and address
//   d_wr, d_wdata       D-side write-through store request (level) and data
//   mem_en, mem_wr      memory issue strobe and write qualifier
//   mem_addr, mem_wdata memory issue address and write data
//   mem_rdata, mem_valid returned read word and its valid strobe
//   fill_data, fill_word word and word offset for the cache data array
//   i_fill_we, d_fill_we data array write enables
//   i_fill_done, d_fill_done one-cycle pulse when a block is complete
//   d_wr_done           one-cycle pulse when a store is accepted by memory
//   busy                arbiter is not in IDLE
//   i_fill_cnt, d_fill_cnt, busy_cyc  performance counters
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8,
    parameter int MEM_LAT   = 4
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         i_miss,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic                         d_miss,
    input  logic                         d_wr,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [DATA_W-1:0]            d_wdata,

    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_valid,

    output logic [DATA_W-1:0]            fill_data,
    output logic [$clog2(BLK_WORDS)-1:0] fill_word,
    output logic                         i_fill_we,
    output logic                         d_fill_we,
    output logic                         i_fill_done,
    output logic                         d_fill_done,
    output logic                         d_wr_done,
    output logic                         busy,

    output logic [15:0]                  i_fill_cnt,
    output logic [15:0]                  d_fill_cnt,
    output logic [15:0]                  busy_cyc
);

    localparam int WORD_W  = $clog2(BLK_WORDS);
    localparam int DRAIN_W = $clog2(MEM_LAT + 1);

    localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(BLK_WORDS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MEM_LAT - 1);
    // Block is BLK_WORDS words of two bytes each; clear the offset bits.
    localparam logic [ADDR_W-1:0]  BLK_MASK   = ~ADDR_W'(2 * BLK_WORDS - 1);

    typedef enum logic [2:0] {
        DRAIN,
        IDLE,
        STORE,
        FILL_I,
        FILL_D,
        DONE_I,
        DONE_D
    } state_t;

    state_t              state;
    state_t              next_state;

    logic [DRAIN_W-1:0]  drain_cnt;
    logic [WORD_W-1:0]   issue_cnt;
    logic                issue_end;
    logic [WORD_W-1:0]   rcv_cnt;
    logic [ADDR_W-1:0]   base;
    logic [ADDR_W-1:0]   issue_off;

    // Byte offset of the word currently being issued within the block.
    assign issue_off = {{(ADDR_W - WORD_W - 1){1'b0}}, issue_cnt, 1'b0};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DRAIN;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // A fill ends on the last returned word, not on the last issue, so the
    // receive counter (which wraps back to zero) is what closes the block.
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (d_wr) begin
                    next_state = STORE;
                end else if (d_miss) begin
                    next_state = FILL_D;
                end else if (i_miss) begin
                    next_state = FILL_I;
                end
            end
            STORE: begin
                next_state = IDLE;
            end
            FILL_I: begin
                if (mem_valid && (rcv_cnt == WORD_LAST)) begin
                    next_state = DONE_I;
                end
            end
            FILL_D: begin
                if (mem_valid && (rcv_cnt == WORD_LAST)) begin
                    next_state = DONE_D;
                end
            end
            DONE_I: begin
                next_state = IDLE;
            end
            DONE_D: begin
                next_state = IDLE;
            end
            default: begin
                next_state = DRAIN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Fill sequencing: drain counter, issue/receive counters, block base.
    // issue_end stops issuing once the 3-bit issue counter has wrapped, since
    // the counter alone cannot tell "not started" from "all issued".
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
            issue_cnt <= '0;
            issue_end <= 1'b0;
            rcv_cnt   <= '0;
            base      <= '0;
        end else begin
            drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;

            case (state)
                IDLE: begin
                    issue_cnt <= '0;
                    issue_end <= 1'b0;
                    rcv_cnt   <= '0;
                    if (next_state == FILL_D) begin
                        base <= d_addr & BLK_MASK;
                    end else if (next_state == FILL_I) begin
                        base <= i_addr & BLK_MASK;
                    end
                end
                FILL_I, FILL_D: begin
                    if (!issue_end) begin
                        issue_cnt <= issue_cnt + WORD_W'(1);
                        if (issue_cnt == WORD_LAST) begin
                            issue_end <= 1'b1;
                        end
                    end
                    if (mem_valid) begin
                        rcv_cnt <= rcv_cnt + WORD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode. Everything defaults to zero, so DRAIN and IDLE drive
    // only busy. Returns arriving outside FILL_x never reach a data array.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_data   = '0;
        fill_word   = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_done   = 1'b0;
        busy        = (state != IDLE);

        case (state)
            STORE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_wr_done = 1'b1;
            end
            FILL_I, FILL_D: begin
                if (!issue_end) begin
                    mem_en   = 1'b1;
                    mem_addr = base + issue_off;
                end
                fill_data = mem_rdata;
                fill_word = rcv_cnt;
                if (state == FILL_I) begin
                    i_fill_we = mem_valid;
                end else begin
                    d_fill_we = mem_valid;
                end
            end
            DONE_I: begin
                i_fill_done = 1'b1;
            end
            DONE_D: begin
                d_fill_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] i_cnt_q;
    logic [15:0] d_cnt_q;
    logic [15:0] busy_q;

    // -------------------------------------------------------------------------
    // Saturating performance counters. DRAIN is excluded from busy time so
    // the count reflects memory traffic only.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            i_cnt_q <= '0;
            d_cnt_q <= '0;
            busy_q  <= '0;
        end else begin
            if (i_fill_done && (i_cnt_q != 16'hFFFF)) begin
                i_cnt_q <= i_cnt_q + 16'd1;
            end
            if (d_fill_done && (d_cnt_q != 16'hFFFF)) begin
                d_cnt_q <= d_cnt_q + 16'd1;
            end
            if (busy && (state != DRAIN) && (busy_q != 16'hFFFF)) begin
                busy_q <= busy_q + 16'd1;
            end
        end
    end

    assign i_fill_cnt = i_cnt_q;
    assign d_fill_cnt = d_cnt_q;
    assign busy_cyc   = busy_q;
`else
    assign i_fill_cnt = 16'h0000;
    assign d_fill_cnt = 16'h0000;
    assign busy_cyc   = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with a scoreboard. Stimulus tasks push the
// expected memory issues, fill writes and done pulses (with the cycle each is
// due) into queues; a monitor on the falling edge pops and compares whenever
// the DUT presents one of them. A small pipelined memory model returns
// memFn(addr) MEM_LAT cycles after every read issue.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;

`ifdef MEM_ARB_PERF_CNT_EN
    localparam int EXP_I_CNT = 3;
    localparam int EXP_D_CNT = 1;
    localparam int EXP_BUSY  = 52;
`else
    localparam int EXP_I_CNT = 0;
    localparam int EXP_D_CNT = 0;
    localparam int EXP_BUSY  = 0;
`endif

    logic        clk;
    logic        rst;
    logic        i_miss;
    logic [15:0] i_addr;
    logic        d_miss;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we;
    logic        d_fill_we;
    logic        i_fill_done;
    logic        d_fill_done;
    logic        d_wr_done;
    logic        busy;
    logic [15:0] i_fill_cnt;
    logic [15:0] d_fill_cnt;
    logic [15:0] busy_cyc;

    mem_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .BLK_WORDS(8),
        .MEM_LAT  (MEM_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_miss     (i_miss),
        .i_addr     (i_addr),
        .d_miss     (d_miss),
        .d_wr       (d_wr),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .fill_data  (fill_data),
        .fill_word  (fill_word),
        .i_fill_we  (i_fill_we),
        .d_fill_we  (d_fill_we),
        .i_fill_done(i_fill_done),
        .d_fill_done(d_fill_done),
        .d_wr_done  (d_wr_done),
        .busy       (busy),
        .i_fill_cnt (i_fill_cnt),
        .d_fill_cnt (d_fill_cnt),
        .busy_cyc   (busy_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number: count of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;

    // Memory contents are a fixed function of the word address.
    function automatic logic [15:0] memFn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    // Pipelined memory model: a read issued in cycle n returns in n+MEM_LAT.
    logic [3:0]  vpipe = 4'b0000;
    logic [15:0] apipe [4] = '{default: 16'h0000};
    always @(posedge clk) begin
        vpipe    <= {vpipe[2:0], (mem_en === 1'b1) && (mem_wr === 1'b0)};
        apipe[0] <= mem_addr;
        apipe[1] <= apipe[0];
        apipe[2] <= apipe[1];
        apipe[3] <= apipe[2];
    end
    assign mem_valid = vpipe[3];
    assign mem_rdata = vpipe[3] ? memFn(apipe[3]) : 16'h0000;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } iss_t;

    typedef struct {
        int          cyc;
        logic        side;
        logic [2:0]  word;
        logic [15:0] data;
    } fill_t;

    typedef struct {
        int         cyc;
        logic [1:0] kind;
    } done_t;

    iss_t  iss_q  [$];
    fill_t fill_q [$];
    done_t done_q [$];

    iss_t  mon_iss;
    fill_t mon_fill;
    done_t mon_done;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cyc, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [31:0] actual);
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected %s at cycle %0d: got 0x%0h, expected none",
                 name, cyc, actual);
    endtask

    task automatic popDone(input logic [1:0] kind);
        if (done_q.size() == 0) begin
            reportUnexpected("done pulse", 32'(kind));
        end else begin
            mon_done = done_q.pop_front();
            checkOutput("done cycle", 32'(cyc), 32'(mon_done.cyc));
            checkOutput("done kind", 32'(kind), 32'(mon_done.kind));
        end
    endtask

    // Monitor: compares everything the DUT presents against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_en) begin
                if (iss_q.size() == 0) begin
                    reportUnexpected("mem issue", 32'(mem_addr));
                end else begin
                    mon_iss = iss_q.pop_front();
                    checkOutput("issue cycle", 32'(cyc), 32'(mon_iss.cyc));
                    checkOutput("issue wr", 32'(mem_wr), 32'(mon_iss.wr));
                    checkOutput("issue addr", 32'(mem_addr), 32'(mon_iss.addr));
                    if (mon_iss.wr) begin
                        checkOutput("issue wdata", 32'(mem_wdata), 32'(mon_iss.wdata));
                    end
                end
            end
            if (i_fill_we || d_fill_we) begin
                if (fill_q.size() == 0) begin
                    reportUnexpected("fill write", 32'({i_fill_we, d_fill_we}));
                end else begin
                    mon_fill = fill_q.pop_front();
                    checkOutput("fill cycle", 32'(cyc), 32'(mon_fill.cyc));
                    checkOutput("fill we {i,d}", 32'({i_fill_we, d_fill_we}),
                                mon_fill.side ? 32'd1 : 32'd2);
                    checkOutput("fill word", 32'(fill_word), 32'(mon_fill.word));
                    checkOutput("fill data", 32'(fill_data), 32'(mon_fill.data));
                end
            end
            if (i_fill_done) popDone(2'd0);
            if (d_fill_done) popDone(2'd1);
            if (d_wr_done)   popDone(2'd2);
        end
    end

    // Push the expected traffic of a full block refill granted in IDLE cycle c0.
    task automatic pushFill(input logic side, input logic [15:0] addr, input int c0);
        iss_t        ie;
        fill_t       fe;
        done_t       de;
        logic [15:0] blk;
        blk = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            ie.cyc   = c0 + 1 + k;
            ie.wr    = 1'b0;
            ie.addr  = blk + 16'(2 * k);
            ie.wdata = 16'h0000;
            iss_q.push_back(ie);
            fe.cyc   = c0 + 5 + k;
            fe.side  = side;
            fe.word  = 3'(k);
            fe.data  = memFn(blk + 16'(2 * k));
            fill_q.push_back(fe);
        end
        de.cyc  = c0 + 13;
        de.kind = side ? 2'd1 : 2'd0;
        done_q.push_back(de);
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for a done pulse (0 = I fill, 1 = D fill, 2 = store).
    task automatic waitDone(input int kind);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge clk);
            #1;
            case (kind)
                0:       got = i_fill_done;
                1:       got = d_fill_done;
                default: got = d_wr_done;
            endcase
        end
        checkOutput("done seen within budget", 32'(got), 32'd1);
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 20 && !idle; k++) begin
            @(posedge clk);
            #1;
            idle = !busy;
        end
        checkOutput("idle within budget", 32'(idle), 32'd1);
    endtask

    // One complete refill from IDLE; the requester drops its miss on done.
    task automatic applyStimulus(input logic side, input logic [15:0] addr);
        int c;
        @(posedge clk);
        #1;
        c = cyc;
        checkOutput("idle before grant", 32'(busy), 32'd0);
        if (side) begin
            d_miss = 1'b1;
            d_addr = addr;
        end else begin
            i_miss = 1'b1;
            i_addr = addr;
        end
        pushFill(side, addr, c);
        waitDone(side ? 1 : 0);
        if (side) d_miss = 1'b0;
        else      i_miss = 1'b0;
    endtask

    initial begin : stimulus
        int    c;
        iss_t  ie;
        done_t de;

        rst     = 1'b1;
        i_miss  = 1'b0;
        i_addr  = 16'h0000;
        d_miss  = 1'b0;
        d_wr    = 1'b0;
        d_addr  = 16'h0000;
        d_wdata = 16'h0000;

        // Reset: two cycles high, then MEM_LAT cycles of DRAIN.
        @(posedge clk);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < MEM_LAT; k++) begin
            checkOutput("drain outputs",
                        32'({busy, mem_en, mem_wr, i_fill_we, d_fill_we,
                             i_fill_done, d_fill_done, d_wr_done}), 32'h80);
            @(posedge clk);
            #1;
        end
        checkOutput("idle flags",
                    32'({busy, mem_en, mem_wr, i_fill_we, d_fill_we,
                         i_fill_done, d_fill_done, d_wr_done}), 32'h00);
        checkOutput("idle mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("idle fill_word/data", 32'({fill_word, fill_data}), 32'h0);
        checkOutput("idle counters", 32'(i_fill_cnt | d_fill_cnt | busy_cyc), 32'h0);

        // I fill of block 0x1230.
        $display("[TB] I fill 0x1236");
        applyStimulus(1'b0, 16'h1236);

        // Contention: D block 0x4000 first, then I block 0x2460.
        $display("[TB] contention I/D");
        @(posedge clk);
        #1;
        c = cyc;
        checkOutput("idle before contention", 32'(busy), 32'd0);
        i_miss = 1'b1;
        i_addr = 16'h2468;
        d_miss = 1'b1;
        d_addr = 16'h4002;
        pushFill(1'b1, 16'h4002, c);
        pushFill(1'b0, 16'h2468, c + 14);
        waitDone(1);
        d_miss = 1'b0;
        waitDone(0);
        i_miss = 1'b0;

        // Store raised during an I fill waits until the fill is done.
        $display("[TB] store during I fill");
        @(posedge clk);
        #1;
        c = cyc;
        i_miss = 1'b1;
        i_addr = 16'h300C;
        pushFill(1'b0, 16'h300C, c);
        ie.cyc   = c + 15;
        ie.wr    = 1'b1;
        ie.addr  = 16'h8000;
        ie.wdata = 16'hBEEF;
        iss_q.push_back(ie);
        de.cyc  = c + 15;
        de.kind = 2'd2;
        done_q.push_back(de);
        waitCycle(c + 3);
        d_wr    = 1'b1;
        d_addr  = 16'h8000;
        d_wdata = 16'hBEEF;
        waitDone(0);
        i_miss = 1'b0;
        waitDone(2);
        d_wr = 1'b0;

        // Reset in fill cycle 6: stale returns land in DRAIN, then a full refill.
        $display("[TB] reset mid-fill");
        @(posedge clk);
        #1;
        c = cyc;
        i_miss = 1'b1;
        i_addr = 16'h5554;
        for (int k = 0; k < 6; k++) begin
            ie.cyc   = c + 1 + k;
            ie.wr    = 1'b0;
            ie.addr  = 16'h5550 + 16'(2 * k);
            ie.wdata = 16'h0000;
            iss_q.push_back(ie);
        end
        for (int k = 0; k < 2; k++) begin
            fill_q.push_back('{c + 5 + k, 1'b0, 3'(k), memFn(16'h5550 + 16'(2 * k))});
        end
        pushFill(1'b0, 16'h5554, c + 11);
        waitCycle(c + 6);
        rst = 1'b1;
        waitCycle(c + 7);
        rst = 1'b0;
        waitCycle(c + 8);
        checkOutput("busy in drain", 32'(busy), 32'd1);
        waitDone(0);
        i_miss = 1'b0;

        // Counters after a fresh reset: 3 I fills and 1 D fill.
        $display("[TB] perf counters");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitIdle();
        checkOutput("counters cleared", 32'(i_fill_cnt | d_fill_cnt | busy_cyc), 32'h0);
        applyStimulus(1'b0, 16'h0100);
        applyStimulus(1'b0, 16'h0200);
        applyStimulus(1'b1, 16'h0300);
        applyStimulus(1'b0, 16'h0400);
        @(posedge clk);
        #1;
        checkOutput("i_fill_cnt", 32'(i_fill_cnt), 32'(EXP_I_CNT));
        checkOutput("d_fill_cnt", 32'(d_fill_cnt), 32'(EXP_D_CNT));
        checkOutput("busy_cyc", 32'(busy_cyc), 32'(EXP_BUSY));

        repeat (8) @(posedge clk);
        #1;
        checkOutput("issue queue drained", 32'(iss_q.size()), 32'd0);
        checkOutput("fill queue drained", 32'(fill_q.size()), 32'd0);
        checkOutput("done queue drained", 32'(done_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
